branch_predict_unit: RTL and testbench

//  Parametrised branch resolve-and-predict unit for the MIPS pipeline; successor to BranchControl.

---
 rtl/branch_predict_unit_if.sv | 29 ++
 rtl/branch_predict_unit.sv | 103 ++++++++++
 tb/tb_branch_predict_unit.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predict_unit_if.sv
// rtl/branch_predict_unit_if.sv - fetch/resolve bus between the pipeline and the branch predict unit
// The pipeline holds the master side; the predictor holds the slave side.
interface branch_predict_unit_if #(
   parameter int PC_W = 32
);
   logic            f_valid;
   logic [PC_W-1:0] f_pc;
   logic            p_valid;
   logic            p_taken;
   logic            r_valid;
   logic [PC_W-1:0] r_pc;
   logic            r_branch;
   logic [2:0]      r_branchop;
   logic            r_zero;
   logic            r_gt;
   logic            r_pred_taken;
   logic            r_taken;
   logic            r_mispredict;

   modport master (
      output f_valid, f_pc, r_valid, r_pc, r_branch, r_branchop, r_zero, r_gt, r_pred_taken,
      input  p_valid, p_taken, r_taken, r_mispredict
   );

   modport slave (
      input  f_valid, f_pc, r_valid, r_pc, r_branch, r_branchop, r_zero, r_gt, r_pred_taken,
      output p_valid, p_taken, r_taken, r_mispredict
   );
endinterface

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - branch resolve, saturating-counter predictor and statistics
// Untagged table indexed by word PC; lookups see the table as it was before this cycle's update.
module branch_predict_unit #(
   parameter int PC_W       = 32,
   parameter int IDX_W      = 6,
   parameter int CNT_W      = 2,
   parameter int INIT_STATE = 1,
   parameter int STAT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   branch_predict_unit_if.slave bus,
   input  logic              clr_stats,
   output logic [STAT_W-1:0] branch_cnt,
   output logic [STAT_W-1:0] mispred_cnt
);
   localparam int               DEPTH    = 1 << IDX_W;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_STATE);

   logic [CNT_W-1:0] table_q [DEPTH];
   logic [IDX_W-1:0] f_idx;
   logic [IDX_W-1:0] r_idx;
   logic [CNT_W-1:0] f_entry;
   logic [CNT_W-1:0] r_entry;
   logic [CNT_W-1:0] r_entry_next;
   logic             cond;
   logic             res_en;
   logic             taken;
   logic             mispredict;
   logic             unused_pc_bits;

   assign f_idx   = bus.f_pc[IDX_W+1:2];
   assign r_idx   = bus.r_pc[IDX_W+1:2];
   assign f_entry = table_q[f_idx];
   assign r_entry = table_q[r_idx];

   // Byte offset and bits above the index do not take part in prediction (aliasing is intended).
   assign unused_pc_bits = ^{bus.f_pc[PC_W-1:IDX_W+2], bus.f_pc[1:0],
                             bus.r_pc[PC_W-1:IDX_W+2], bus.r_pc[1:0]};

   always_comb begin
      cond = 1'b0;
      case (bus.r_branchop)
         3'b000:  cond = bus.r_zero;
         3'b001:  cond = !bus.r_zero;
         3'b010:  cond = bus.r_gt;
         3'b011:  cond = bus.r_gt | bus.r_zero;
         3'b100:  cond = !bus.r_gt & !bus.r_zero;
         3'b101:  cond = !bus.r_gt | bus.r_zero;
         3'b110:  cond = 1'b1;
         default: cond = 1'b0;
      endcase
   end

   assign res_en     = bus.r_valid & bus.r_branch;
   assign taken      = res_en & cond;
   assign mispredict = res_en & (cond != bus.r_pred_taken);

   always_comb begin
      r_entry_next = r_entry;
      if (taken) begin
         if (r_entry != {CNT_W{1'b1}}) r_entry_next = r_entry + 1'b1;
      end else begin
         if (r_entry != {CNT_W{1'b0}}) r_entry_next = r_entry - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) table_q[i] <= CNT_INIT;
      end else if (res_en) begin
         table_q[r_idx] <= r_entry_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.p_valid      <= 1'b0;
         bus.p_taken      <= 1'b0;
         bus.r_taken      <= 1'b0;
         bus.r_mispredict <= 1'b0;
      end else begin
         bus.p_valid      <= bus.f_valid;
         bus.p_taken      <= bus.f_valid & f_entry[CNT_W-1];
         bus.r_taken      <= taken;
         bus.r_mispredict <= mispredict;
      end
   end

   // Clear wins over the increments that land on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else if (clr_stats) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else begin
         if (res_en && (branch_cnt != {STAT_W{1'b1}}))      branch_cnt  <= branch_cnt + 1'b1;
         if (mispredict && (mispred_cnt != {STAT_W{1'b1}})) mispred_cnt <= mispred_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - randomized self-checking bench for branch_predict_unit
// Reference model: integer counter table and integer statistics updated from the branch rules.
module tb_branch_predict_unit;
   localparam int PC_W   = 32;
   localparam int IDX_W  = 6;
   localparam int CNT_W  = 2;
   localparam int INIT   = 1;
   localparam int STAT_W = 4;
   localparam int DEPTH  = 1 << IDX_W;
   localparam int CMAX   = (1 << CNT_W) - 1;
   localparam int CHALF  = 1 << (CNT_W - 1);
   localparam int SMAX   = (1 << STAT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              clr_stats = 1'b0;
   logic [STAT_W-1:0] branch_cnt;
   logic [STAT_W-1:0] mispred_cnt;

   branch_predict_unit_if #(.PC_W(PC_W)) bus ();

   branch_predict_unit #(
      .PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .INIT_STATE(INIT), .STAT_W(STAT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .clr_stats(clr_stats),
      .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   int tbl [DEPTH];
   int bcnt, mcnt;
   bit exp_p_valid, exp_p_taken, exp_r_taken, exp_r_mis;

   function automatic int idx_of(input logic [PC_W-1:0] pc);
      return int'((pc / 4) % DEPTH);
   endfunction

   function automatic bit cond_of(input int op, input bit z, input bit g);
      case (op)
         0: return z;
         1: return !z;
         2: return g;
         3: return g || z;
         4: return !g && !z;
         5: return !g || z;
         6: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) tbl[i] = INIT;
      bcnt = 0; mcnt = 0;
      exp_p_valid = 0; exp_p_taken = 0; exp_r_taken = 0; exp_r_mis = 0;
   endtask

   task automatic drive_idle();
      bus.f_valid = 0; bus.f_pc = '0;
      bus.r_valid = 0; bus.r_pc = '0; bus.r_branch = 0; bus.r_branchop = '0;
      bus.r_zero = 0; bus.r_gt = 0; bus.r_pred_taken = 0;
      clr_stats = 0;
   endtask

   task automatic set_fetch(input logic [PC_W-1:0] pc);
      bus.f_valid = 1; bus.f_pc = pc;
   endtask

   task automatic set_resolve(input logic [PC_W-1:0] pc, input bit br, input int op,
                              input bit z, input bit g, input bit pred);
      bus.r_valid = 1; bus.r_pc = pc; bus.r_branch = br; bus.r_branchop = 3'(op);
      bus.r_zero = z; bus.r_gt = g; bus.r_pred_taken = pred;
   endtask

   // Advance one clock, predicting from the current inputs what the DUT must show afterwards.
   task automatic tick();
      int fi, ri;
      bit c, en;
      fi = idx_of(bus.f_pc);
      ri = idx_of(bus.r_pc);
      en = bus.r_valid && bus.r_branch;
      c  = cond_of(int'(bus.r_branchop), bus.r_zero, bus.r_gt);
      exp_p_valid = bus.f_valid;
      exp_p_taken = bus.f_valid && (tbl[fi] >= CHALF);
      exp_r_taken = en && c;
      exp_r_mis   = en && (c != bus.r_pred_taken);
      if (en) tbl[ri] = c ? ((tbl[ri] + 1 > CMAX) ? CMAX : tbl[ri] + 1)
                          : ((tbl[ri] - 1 < 0) ? 0 : tbl[ri] - 1);
      if (clr_stats) begin
         bcnt = 0; mcnt = 0;
      end else begin
         if (en && bcnt < SMAX) bcnt++;
         if (exp_r_mis && mcnt < SMAX) mcnt++;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      drive_idle();
      rst_n = 0;
      model_reset();
      @(posedge clk); #1;
      rst_n = 1;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (bus.p_valid !== 1'b0 || bus.p_taken !== 1'b0) begin bad++;
         $display("FAIL reset_pred: got v=%0b t=%0b expected 0 0", bus.p_valid, bus.p_taken); end
      total++; if (bus.r_taken !== 1'b0 || bus.r_mispredict !== 1'b0) begin bad++;
         $display("FAIL reset_resolve: got t=%0b m=%0b expected 0 0", bus.r_taken, bus.r_mispredict); end
      total++; if (branch_cnt !== 0 || mispred_cnt !== 0) begin bad++;
         $display("FAIL reset_stats: got %0d %0d expected 0 0", branch_cnt, mispred_cnt); end
      set_fetch(32'h0040_0000);
      tick();
      drive_idle();
      total++; if (bus.p_valid !== 1'b1 || bus.p_taken !== 1'b0) begin bad++;
         $display("FAIL reset_lookup: got v=%0b t=%0b expected 1 0", bus.p_valid, bus.p_taken); end
   endtask

   task automatic test_cond_sweep();
      int b0;
      for (int op = 0; op < 8; op++) begin
         for (int zg = 0; zg < 4; zg++) begin
            drive_idle();
            set_resolve(32'h0040_0000 + ($urandom_range(0, 63) << 2), 1, op, zg[0], zg[1], $urandom_range(0, 1));
            tick();
            total++; if (bus.r_taken !== exp_r_taken || bus.r_mispredict !== exp_r_mis) begin bad++;
               $display("FAIL cond op=%0d z=%0d g=%0d: got t=%0b m=%0b expected %0b %0b",
                        op, zg[0], zg[1], bus.r_taken, bus.r_mispredict, exp_r_taken, exp_r_mis); end
         end
      end
      drive_idle();
      b0 = int'(branch_cnt);
      set_resolve(32'h0040_0010, 0, 6, 1, 0, 0);
      tick();
      total++; if (bus.r_taken !== 1'b0 || int'(branch_cnt) !== b0) begin bad++;
         $display("FAIL not_branch: got t=%0b cnt=%0d expected 0 %0d", bus.r_taken, branch_cnt, b0); end
      drive_idle();
      set_fetch(32'h0040_0010);
      tick();
      total++; if (bus.p_taken !== exp_p_taken) begin bad++;
         $display("FAIL not_branch_entry: got %0b expected %0b", bus.p_taken, exp_p_taken); end
   endtask

   task automatic test_training();
      do_reset();
      for (int n = 0; n < 9; n++) begin
         drive_idle();
         if (n < 7) set_resolve(32'h0040_0010, 1, 0, 1, 0, 0);
         else       set_resolve(32'h0040_0010, 1, 0, 0, 0, 1);
         tick();
         drive_idle();
         set_fetch(32'h0040_0010);
         tick();
         if (n == 1 || n == 6 || n == 7) begin
            total++; if (bus.p_taken !== 1'b1) begin bad++;
               $display("FAIL train_%0d: got %0b expected 1", n, bus.p_taken); end
         end
         if (n == 8) begin
            total++; if (bus.p_taken !== 1'b0) begin bad++;
               $display("FAIL train_untrain: got %0b expected 0", bus.p_taken); end
         end
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      set_fetch(32'h0040_0020);
      set_resolve(32'h0040_0020, 1, 0, 1, 0, 0);
      tick();
      drive_idle();
      total++; if (bus.p_taken !== 1'b0) begin bad++;
         $display("FAIL same_cycle_old: got %0b expected 0", bus.p_taken); end
      set_fetch(32'h0040_0020);
      tick();
      total++; if (bus.p_taken !== 1'b1) begin bad++;
         $display("FAIL same_cycle_new: got %0b expected 1", bus.p_taken); end
   endtask

   task automatic test_mispredict();
      drive_idle();
      clr_stats = 1;
      tick();
      drive_idle();
      set_resolve(32'h0040_0020, 1, 1, 1, 0, 1);
      tick();
      drive_idle();
      total++; if (bus.r_mispredict !== 1'b1 || bus.r_taken !== 1'b0) begin bad++;
         $display("FAIL mispredict: got m=%0b t=%0b expected 1 0", bus.r_mispredict, bus.r_taken); end
      total++; if (mispred_cnt !== 1) begin bad++;
         $display("FAIL mispred_cnt: got %0d expected 1", mispred_cnt); end
      set_fetch(32'h0040_0120);
      tick();
      total++; if (bus.p_taken !== exp_p_taken || bus.p_taken !== 1'b0) begin bad++;
         $display("FAIL alias: got %0b expected %0b", bus.p_taken, exp_p_taken); end
   endtask

   task automatic test_stats();
      drive_idle();
      clr_stats = 1;
      tick();
      for (int n = 0; n < 20; n++) begin
         drive_idle();
         set_resolve(32'h0040_0000 + ($urandom_range(0, 63) << 2), 1, $urandom_range(0, 7),
                     $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
         tick();
         total++; if (int'(branch_cnt) !== bcnt || int'(mispred_cnt) !== mcnt) begin bad++;
            $display("FAIL stats_%0d: got %0d %0d expected %0d %0d", n, branch_cnt, mispred_cnt, bcnt, mcnt); end
      end
      total++; if (branch_cnt !== 4'd15) begin bad++;
         $display("FAIL stats_sat: got %0d expected 15", branch_cnt); end
      drive_idle();
      set_resolve(32'h0040_0004, 1, 6, 0, 0, 0);
      clr_stats = 1;
      tick();
      drive_idle();
      total++; if (branch_cnt !== 0 || mispred_cnt !== 0) begin bad++;
         $display("FAIL stats_clr: got %0d %0d expected 0 0", branch_cnt, mispred_cnt); end
   endtask

   task automatic test_random(input int cycles);
      for (int n = 0; n < cycles; n++) begin
         drive_idle();
         bus.f_valid = 1'($urandom_range(0, 1));
         bus.f_pc = 32'h0040_0000 + ($urandom_range(0, 3) << 8) + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
         set_resolve(32'h0040_0000 + ($urandom_range(0, 3) << 8) + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3),
                     $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom_range(0, 1));
         bus.r_valid = 1'($urandom_range(0, 7) != 0);
         clr_stats = ($urandom_range(0, 40) == 0);
         tick();
         total++; if (bus.p_valid !== exp_p_valid || bus.p_taken !== exp_p_taken ||
                      bus.r_taken !== exp_r_taken || bus.r_mispredict !== exp_r_mis) begin bad++;
            $display("FAIL rand_out cyc=%0d: got %0b%0b%0b%0b expected %0b%0b%0b%0b", n,
                     bus.p_valid, bus.p_taken, bus.r_taken, bus.r_mispredict,
                     exp_p_valid, exp_p_taken, exp_r_taken, exp_r_mis); end
         total++; if (int'(branch_cnt) !== bcnt || int'(mispred_cnt) !== mcnt) begin bad++;
            $display("FAIL rand_stats cyc=%0d: got %0d %0d expected %0d %0d", n, branch_cnt, mispred_cnt, bcnt, mcnt); end
      end
      drive_idle();
   endtask

   task automatic test_reset_mid_update();
      for (int n = 0; n < 3; n++) begin
         drive_idle();
         set_resolve(32'h0040_0020, 1, 6, 0, 0, 0);
         tick();
      end
      set_resolve(32'h0040_0024, 1, 6, 0, 0, 1);
      #2 rst_n = 0;
      #1;
      total++; if (bus.r_taken !== 1'b0 || branch_cnt !== 0) begin bad++;
         $display("FAIL async_reset: got t=%0b cnt=%0d expected 0 0", bus.r_taken, branch_cnt); end
      drive_idle();
      model_reset();
      @(posedge clk); #1;
      rst_n = 1;
      for (int i = 0; i < DEPTH; i++) begin
         set_fetch(32'h0040_0000 + (i << 2));
         tick();
         total++; if (bus.p_taken !== 1'b0 || bus.p_valid !== 1'b1) begin bad++;
            $display("FAIL reset_entry_%0d: got v=%0b t=%0b expected 1 0", i, bus.p_valid, bus.p_taken); end
      end
      drive_idle();
      set_resolve(32'h0040_0024, 1, 6, 0, 0, 0);
      tick();
      drive_idle();
      set_fetch(32'h0040_0024);
      tick();
      drive_idle();
      total++; if (bus.p_taken !== 1'b1) begin bad++;
         $display("FAIL reset_init_value: got %0b expected 1", bus.p_taken); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      drive_idle();
      model_reset();
      test_reset();
      test_cond_sweep();
      test_training();
      test_same_cycle();
      test_mispredict();
      test_stats();
      test_random(400);
      test_reset_mid_update();
      test_random(200);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
